// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port driver: command/response codes,
// bus widths and the request-sequencing FSM state type.
package calc1_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int TXN_W  = CMD_W + 2 * DATA_W;

    localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
    localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
    localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
    localparam logic [0:CMD_W-1] CMD_SHL = 4'd5;
    localparam logic [0:CMD_W-1] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2,
        ST_WAIT,
        ST_CPL
    } state_t;

endpackage

// File: rtl/calc1_txn_fifo.sv
// Synchronous transaction FIFO holding {cmd, op1, op2}; head entry is
// presented combinationally on dout.
module calc1_txn_fifo
    import calc1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [0:TXN_W-1] din,
    output logic [0:TXN_W-1] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [0:TXN_W-1] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when the head is popped the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/calc1_port_driver.sv
// Request-side driver for one calc1 port: buffers transactions, serialises
// them onto the two-cycle request protocol and returns a completion.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              txn_valid,
    output logic              txn_ready,
    input  logic [0:CMD_W-1]  txn_cmd,
    input  logic [0:DATA_W-1] txn_op1,
    input  logic [0:DATA_W-1] txn_op2,
    output logic [0:CMD_W-1]  req_cmd_out,
    output logic [0:DATA_W-1] req_data_out,
    input  logic [0:1]        calc_resp_in,
    input  logic [0:DATA_W-1] calc_data_in,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [0:1]        cpl_resp,
    output logic [0:DATA_W-1] cpl_data,
    output logic              cpl_timeout,
    output logic              spurious_resp,
    output logic              drop_cmd
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t            state;
    logic [0:TXN_W-1]  head;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [0:DATA_W-1] hold_op2;
    logic [CNT_W-1:0]  wait_cnt;

    assign txn_ready = !full;
    assign accept    = txn_valid && txn_ready;
    assign push      = accept && (txn_cmd != CMD_NOP);
    assign pop       = (state == ST_IDLE) && !empty;

    calc1_txn_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .c_clk (c_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({txn_cmd, txn_op1, txn_op2}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // The SEND1 wire values are loaded on the pop so they appear exactly in SEND1.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            hold_op2      <= '0;
            wait_cnt      <= '0;
            req_cmd_out   <= '0;
            req_data_out  <= '0;
            cpl_valid     <= 1'b0;
            cpl_resp      <= '0;
            cpl_data      <= '0;
            cpl_timeout   <= 1'b0;
            spurious_resp <= 1'b0;
            drop_cmd      <= 1'b0;
        end else begin
            drop_cmd      <= accept && (txn_cmd == CMD_NOP);
            spurious_resp <= (state != ST_WAIT) && (calc_resp_in != RESP_NONE);
            case (state)
                ST_IDLE: begin
                    req_cmd_out  <= '0;
                    req_data_out <= '0;
                    if (!empty) begin
                        req_cmd_out  <= head[0:CMD_W-1];
                        req_data_out <= head[CMD_W:CMD_W+DATA_W-1];
                        hold_op2     <= head[CMD_W+DATA_W:TXN_W-1];
                        state        <= ST_SEND1;
                    end
                end
                ST_SEND1: begin
                    req_cmd_out  <= '0;
                    req_data_out <= hold_op2;
                    state        <= ST_SEND2;
                end
                ST_SEND2: begin
                    req_cmd_out  <= '0;
                    req_data_out <= '0;
                    wait_cnt     <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response on the final counted cycle still beats the timeout.
                    if (calc_resp_in != RESP_NONE) begin
                        cpl_resp    <= calc_resp_in;
                        cpl_data    <= calc_data_in;
                        cpl_timeout <= 1'b0;
                        cpl_valid   <= 1'b1;
                        state       <= ST_CPL;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        cpl_resp    <= RESP_NONE;
                        cpl_data    <= '0;
                        cpl_timeout <= 1'b1;
                        cpl_valid   <= 1'b1;
                        state       <= ST_CPL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CPL: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Self-checking bench for calc1_port_driver with a behavioural calc1 port stub.
module tb_calc1_port_driver;
    import calc1_pkg::*;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        txn_valid;
    logic        txn_ready;
    logic [0:3]  txn_cmd;
    logic [0:31] txn_op1;
    logic [0:31] txn_op2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  calc_resp_in;
    logic [0:31] calc_data_in;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [0:1]  cpl_resp;
    logic [0:31] cpl_data;
    logic        cpl_timeout;
    logic        spurious_resp;
    logic        drop_cmd;

    logic [0:1]  force_resp;
    logic [0:1]  stub_resp;
    logic [0:31] stub_data;
    logic        stub_enable;
    int          stub_delay;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [0:1]  resp;
        logic [0:31] data;
        logic        to;
    } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic [0:3]  cmd;
        logic [0:31] op1;
        logic [0:31] op2;
        logic [0:1]  resp;
        logic [0:31] data;
    } vec_t;
    vec_t vecs [7];

    int cyc = 0;
    int acc_cyc = 0;
    int send1_cyc = 0;
    int send_cnt = 0;
    int cpl_cnt = 0;
    int drop_cnt = 0;
    int spur_cnt = 0;
    int last_wait = 0;
    int wait_cnt = 0;
    int countdown = 0;
    int phase = 0;
    logic        resp_hold = 1'b0;
    logic [0:3]  s_cmd;
    logic [0:31] s_op1;
    logic [0:31] s_op2;

    assign calc_resp_in = (force_resp != 2'd0) ? force_resp : stub_resp;
    assign calc_data_in = stub_data;

    calc1_port_driver #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (64)
    ) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .txn_valid     (txn_valid),
        .txn_ready     (txn_ready),
        .txn_cmd       (txn_cmd),
        .txn_op1       (txn_op1),
        .txn_op2       (txn_op2),
        .req_cmd_out   (req_cmd_out),
        .req_data_out  (req_data_out),
        .calc_resp_in  (calc_resp_in),
        .calc_data_in  (calc_data_in),
        .cpl_valid     (cpl_valid),
        .cpl_ready     (cpl_ready),
        .cpl_resp      (cpl_resp),
        .cpl_data      (cpl_data),
        .cpl_timeout   (cpl_timeout),
        .spurious_resp (spurious_resp),
        .drop_cmd      (drop_cmd)
    );

    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour of a calc1 port for the commands this bench uses.
    function automatic void calc1_model(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                                        output logic [0:1] r, output logic [0:31] d);
        logic [0:32] s;
        r = RESP_ERR;
        d = '0;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[0]) begin
                    r = RESP_OK;
                    d = s[1:32];
                end
            end
            4'd2: if (a >= b) begin
                r = RESP_OK;
                d = a - b;
            end
            4'd5: begin
                r = RESP_OK;
                d = a << b[27:31];
            end
            4'd6: begin
                r = RESP_OK;
                d = a >> b[27:31];
            end
            default: ;
        endcase
    endfunction

    // calc1 port stub: observes the request wire and answers stub_delay WAIT cycles later.
    always @(negedge c_clk) begin
        if (reset) begin
            phase = 0;
            stub_resp = '0;
            stub_data = '0;
            resp_hold = 1'b0;
            countdown = 0;
        end else begin
            if (resp_hold) begin
                stub_resp = '0;
                stub_data = '0;
                resp_hold = 1'b0;
            end
            case (phase)
                0: if (req_cmd_out != 4'd0) begin
                    s_cmd = req_cmd_out;
                    s_op1 = req_data_out;
                    send1_cyc = cyc;
                    send_cnt++;
                    checkOutput("send1_while_cpl", 32'(cpl_valid), 32'd0);
                    phase = 1;
                end
                1: begin
                    checkOutput("send2_cmd_zero", 32'(req_cmd_out), 32'd0);
                    s_op2 = req_data_out;
                    countdown = stub_delay;
                    wait_cnt = 0;
                    phase = 2;
                end
                default: begin
                    if (cpl_valid) begin
                        last_wait = wait_cnt;
                        phase = 0;
                    end else begin
                        wait_cnt++;
                        if (stub_enable && countdown != 0) begin
                            countdown--;
                            if (countdown == 0) begin
                                calc1_model(s_cmd, s_op1, s_op2, stub_resp, stub_data);
                                resp_hold = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Completion scoreboard and pulse counters.
    always @(negedge c_clk) begin
        if (!reset) begin
            if (drop_cmd) drop_cnt++;
            if (spurious_resp) spur_cnt++;
            if (cpl_valid && cpl_ready) begin
                cpl_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("cpl_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("cpl_resp", 32'(cpl_resp), 32'(e.resp));
                    checkOutput("cpl_data", cpl_data, e.data);
                    checkOutput("cpl_timeout", 32'(cpl_timeout), 32'(e.to));
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that took the transaction.
    task automatic applyStimulus(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                                 input logic [0:1] er, input logic [0:31] ed, input logic et);
        int budget = 500;
        txn_cmd = c;
        txn_op1 = a;
        txn_op2 = b;
        txn_valid = 1'b1;
        @(negedge c_clk);
        while (!txn_ready && budget > 0) begin
            @(negedge c_clk);
            budget--;
        end
        if (!txn_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc_cyc = cyc;
            if (c != 4'd0) exp_q.push_back('{resp: er, data: ed, to: et});
        end
        @(posedge c_clk);
        #1;
        txn_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge c_clk);
            #1;
            budget--;
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        @(negedge c_clk);
        checkOutput({tag, "_req_cmd"}, 32'(req_cmd_out), 32'd0);
        checkOutput({tag, "_req_data"}, req_data_out, 32'd0);
        checkOutput({tag, "_cpl_valid"}, 32'(cpl_valid), 32'd0);
        checkOutput({tag, "_cpl_resp"}, 32'(cpl_resp), 32'd0);
        checkOutput({tag, "_cpl_data"}, cpl_data, 32'd0);
        checkOutput({tag, "_cpl_timeout"}, 32'(cpl_timeout), 32'd0);
        checkOutput({tag, "_spurious"}, 32'(spurious_resp), 32'd0);
        checkOutput({tag, "_drop"}, 32'(drop_cmd), 32'd0);
        checkOutput({tag, "_txn_ready"}, 32'(txn_ready), 32'd1);
        @(posedge c_clk);
        #1;
    endtask

    initial begin
        int d0;
        int s0;
        int c0;
        int sp0;

        vecs[0] = '{CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF, RESP_OK,  32'h2000_0000};
        vecs[1] = '{CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, RESP_ERR, 32'h0000_0000};
        vecs[2] = '{CMD_SUB, 32'h0000_0001, 32'h0000_000F, RESP_ERR, 32'h0000_0000};
        vecs[3] = '{CMD_SUB, 32'h0000_0010, 32'h0000_0003, RESP_OK,  32'h0000_000D};
        vecs[4] = '{CMD_SHL, 32'h0000_0003, 32'h0000_0004, RESP_OK,  32'h0000_0030};
        vecs[5] = '{CMD_SHR, 32'h8000_0000, 32'h0000_001F, RESP_OK,  32'h0000_0001};
        vecs[6] = '{4'd9,    32'h0000_0005, 32'h0000_0005, RESP_ERR, 32'h0000_0000};

        reset = 1'b1;
        txn_valid = 1'b0;
        txn_cmd = '0;
        txn_op1 = '0;
        txn_op2 = '0;
        cpl_ready = 1'b1;
        force_resp = '0;
        stub_enable = 1'b1;
        stub_delay = 3;
        repeat (3) @(posedge c_clk);
        #1;
        reset = 1'b0;
        checkIdleOutputs("reset");

        for (int i = 0; i < 7; i++) begin
            stub_delay = 1 + i;
            applyStimulus(vecs[i].cmd, vecs[i].op1, vecs[i].op2, vecs[i].resp, vecs[i].data, 1'b0);
            waitDrain(200);
            if (i == 0) checkOutput("push_to_send1", 32'(send1_cyc - acc_cyc), 32'd2);
        end

        // Response on the 64th WAIT cycle still wins over the timeout.
        stub_delay = 64;
        applyStimulus(CMD_ADD, 32'd2, 32'd3, RESP_OK, 32'd5, 1'b0);
        waitDrain(200);
        checkOutput("late_resp_wait_cycles", 32'(last_wait), 32'd64);

        stub_enable = 1'b0;
        applyStimulus(CMD_ADD, 32'd7, 32'd8, RESP_NONE, 32'd0, 1'b1);
        waitDrain(200);
        checkOutput("timeout_wait_cycles", 32'(last_wait), 32'd64);
        stub_enable = 1'b1;

        // Backpressure: one in flight plus four buffered fills the driver.
        stub_delay = 2;
        cpl_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(CMD_ADD, 32'(i + 1), 32'h100 * 32'(i + 1), RESP_OK, 32'(i + 1) + 32'h100 * 32'(i + 1), 1'b0);
        end
        @(negedge c_clk);
        checkOutput("full_txn_ready", 32'(txn_ready), 32'd0);
        repeat (10) @(posedge c_clk);
        #1;
        @(negedge c_clk);
        checkOutput("held_txn_ready", 32'(txn_ready), 32'd0);
        checkOutput("held_cpl_valid", 32'(cpl_valid), 32'd1);
        checkOutput("held_cpl_data", cpl_data, 32'h0000_0101);
        @(posedge c_clk);
        #1;
        cpl_ready = 1'b1;
        waitDrain(600);

        d0 = drop_cnt;
        s0 = send_cnt;
        c0 = cpl_cnt;
        applyStimulus(CMD_NOP, 32'h1234_5678, 32'h9ABC_DEF0, RESP_NONE, 32'd0, 1'b0);
        repeat (8) @(posedge c_clk);
        #1;
        checkOutput("drop_pulses", 32'(drop_cnt - d0), 32'd1);
        checkOutput("drop_no_send", 32'(send_cnt - s0), 32'd0);
        checkOutput("drop_no_cpl", 32'(cpl_cnt - c0), 32'd0);

        sp0 = spur_cnt;
        force_resp = RESP_OK;
        @(posedge c_clk);
        #1;
        force_resp = '0;
        repeat (4) @(posedge c_clk);
        #1;
        checkOutput("spurious_pulses", 32'(spur_cnt - sp0), 32'd1);
        checkOutput("spurious_no_cpl", 32'(cpl_cnt - c0), 32'd0);

        // Reset while waiting for a response abandons the transaction.
        stub_enable = 1'b0;
        s0 = send_cnt;
        applyStimulus(CMD_SUB, 32'd9, 32'd4, RESP_OK, 32'd5, 1'b0);
        repeat (12) @(posedge c_clk);
        #1;
        checkOutput("rst_wait_sent", 32'(send_cnt - s0), 32'd1);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        c0 = cpl_cnt;
        checkIdleOutputs("midwait_reset");
        repeat (100) @(posedge c_clk);
        #1;
        checkOutput("abandoned_no_cpl", 32'(cpl_cnt - c0), 32'd0);
        checkOutput("spurious_total", 32'(spur_cnt), 32'd1);
        stub_enable = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
